// File: rtl/bch_div_scheduler_if.sv
// Request/response and divider-side signals of the round-robin divider scheduler.
// master = requesters plus divider (environment); slave = the scheduler.
interface bch_div_scheduler_if #(
  parameter int NREQ   = 2,
  parameter int DATA_W = 31,
  parameter int CODE_W = 5
);
  localparam int GID_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]        req_valid;
  logic [NREQ*DATA_W-1:0] req_data;
  logic [NREQ*CODE_W-1:0] req_poly;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ-1:0]        rsp_valid;
  logic [CODE_W-2:0]      rsp_rem;
  logic                   rsp_err;
  logic                   busy;
  logic [GID_W-1:0]       grant_id;
  logic                   div_readready;
  logic [DATA_W-1:0]      div_data;
  logic [CODE_W-1:0]      div_codeword;
  logic                   div_reset;
  logic                   div_outready;
  logic [CODE_W-2:0]      div_remainder;

  modport master (
    output req_valid, req_data, req_poly, div_outready, div_remainder,
    input  req_ready, rsp_valid, rsp_rem, rsp_err, busy, grant_id,
           div_readready, div_data, div_codeword, div_reset
  );

  modport slave (
    input  req_valid, req_data, req_poly, div_outready, div_remainder,
    output req_ready, rsp_valid, rsp_rem, rsp_err, busy, grant_id,
           div_readready, div_data, div_codeword, div_reset
  );
endinterface

// File: rtl/bch_div_scheduler.sv
// Round-robin scheduler sharing one serial polynomial divider between NREQ requesters.
//   state   | meaning
//   IDLE    | waiting for any req_valid; arbitrate and latch the winner's job
//   ISSUE   | accept pulse to winner, start pulse to divider, clear timer
//   WAIT    | wait for divider done or watchdog expiry
//   RESPOND | one-cycle result pulse; divider reset on timeout
module bch_div_scheduler #(
  parameter int NREQ    = 2,
  parameter int DATA_W  = 31,
  parameter int CODE_W  = 5,
  parameter int TIMEOUT = 128
) (
  input  logic                 clk,
  input  logic                 reset,
  bch_div_scheduler_if.slave   bus
);
  localparam int GID_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST   = TMR_W'(TIMEOUT - 1);
  localparam logic [GID_W-1:0] GRANT_LAST = GID_W'(NREQ - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT    = 2'd2,
    S_RESPOND = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [GID_W-1:0]   last_grant_q, last_grant_d;
  logic [GID_W-1:0]   grant_q, grant_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [CODE_W-1:0]  poly_q, poly_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [CODE_W-2:0]  rem_q, rem_d;
  logic               err_q, err_d;

  logic [GID_W-1:0]   win;
  logic               found;
  logic [NREQ-1:0]    req_ready_w;
  logic [NREQ-1:0]    rsp_valid_w;

  // Search starts one past the last served requester, so it has lowest priority.
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      if (!found && bus.req_valid[(int'(last_grant_q) + i) % NREQ]) begin
        found = 1'b1;
        win   = GID_W'((int'(last_grant_q) + i) % NREQ);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    data_d       = data_q;
    poly_d       = poly_q;
    timer_d      = timer_q;
    rem_d        = rem_q;
    err_d        = err_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          grant_d = win;
          data_d  = bus.req_data[win*DATA_W +: DATA_W];
          poly_d  = bus.req_poly[win*CODE_W +: CODE_W];
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.div_outready) begin
          rem_d   = bus.div_remainder;
          err_d   = 1'b0;
          state_d = S_RESPOND;
        end else if (timer_q == TMR_LAST) begin
          rem_d   = '0;
          err_d   = 1'b1;
          state_d = S_RESPOND;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_RESPOND: begin
        last_grant_d = grant_q;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      last_grant_q <= GRANT_LAST;
      grant_q      <= '0;
      data_q       <= '0;
      poly_q       <= '0;
      timer_q      <= '0;
      rem_q        <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      data_q       <= data_d;
      poly_q       <= poly_d;
      timer_q      <= timer_d;
      rem_q        <= rem_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    req_ready_w = '0;
    rsp_valid_w = '0;
    if (state_q == S_ISSUE)   req_ready_w[grant_q] = 1'b1;
    if (state_q == S_RESPOND) rsp_valid_w[grant_q] = 1'b1;
  end

  assign bus.req_ready     = req_ready_w;
  assign bus.rsp_valid     = rsp_valid_w;
  assign bus.rsp_rem       = (state_q == S_RESPOND) ? rem_q : '0;
  assign bus.rsp_err       = (state_q == S_RESPOND) && err_q;
  assign bus.busy          = (state_q != S_IDLE);
  assign bus.grant_id      = grant_q;
  assign bus.div_readready = (state_q == S_ISSUE);
  assign bus.div_data      = data_q;
  assign bus.div_codeword  = poly_q;
  // A timed-out divider is reset alongside the error response.
  assign bus.div_reset     = reset || ((state_q == S_RESPOND) && err_q);

endmodule

// File: tb/tb_bch_div_scheduler.sv
// Bench for bch_div_scheduler: GF(2) divider model plus round-robin reference.
module tb_bch_div_scheduler;
  localparam int NREQ    = 2;
  localparam int DATA_W  = 31;
  localparam int CODE_W  = 5;
  localparam int TIMEOUT = 128;

  logic clk;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  bch_div_scheduler_if #(.NREQ(NREQ), .DATA_W(DATA_W), .CODE_W(CODE_W)) bus ();

  bch_div_scheduler #(.NREQ(NREQ), .DATA_W(DATA_W), .CODE_W(CODE_W), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DATA_W-1:0] rd [NREQ];
  logic [CODE_W-1:0] rp [NREQ];
  logic [NREQ-1:0]   pending;
  int                exp_last;

  function automatic logic [CODE_W-2:0] gf_mod(input logic [DATA_W-1:0] d, input logic [CODE_W-1:0] g);
    logic [DATA_W-1:0] r;
    r = d;
    for (int b = DATA_W-1; b >= CODE_W-1; b--)
      if (r[b]) r = r ^ (DATA_W'(g) << (b - (CODE_W-1)));
    return r[CODE_W-2:0];
  endfunction

  function automatic int rr_pick(input int last, input logic [NREQ-1:0] m);
    for (int k = 1; k <= NREQ; k++)
      if (m[(last + k) % NREQ]) return (last + k) % NREQ;
    return -1;
  endfunction

  task automatic drive_reqs();
    bus.req_valid = pending;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_data[i*DATA_W +: DATA_W] = rd[i];
      bus.req_poly[i*CODE_W +: CODE_W] = rp[i];
    end
  endtask

  task automatic new_job(input int i);
    rd[i] = DATA_W'($urandom);
    rp[i] = {1'b1, (CODE_W-1)'($urandom)};
  endtask

  // delay: idle WAIT cycles before done (-1 = never); spur: done pulse during ISSUE
  task automatic do_job(input int delay, input bit hold, input bit spur, output int w);
    int exp_c;
    bit exp_err;
    logic [CODE_W-2:0] exp_rem;
    int got_c;
    w = rr_pick(exp_last, pending);
    if (w < 0) begin
      checks++; errors++;
      $display("FAIL job_setup: no pending requester");
      return;
    end
    exp_err = (delay < 0) || (delay >= TIMEOUT);
    exp_c   = exp_err ? TIMEOUT : delay + 1;
    exp_rem = exp_err ? '0 : gf_mod(rd[w], rp[w]);
    drive_reqs();
    @(posedge clk); @(negedge clk);
    checks++;
    if (bus.req_ready !== (NREQ'(1) << w) || bus.div_readready !== 1'b1 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL issue: req_ready=%b readready=%b busy=%b required req_ready=%b readready=1 busy=1",
               bus.req_ready, bus.div_readready, bus.busy, NREQ'(1) << w);
    end
    checks++;
    if (bus.div_data !== rd[w] || bus.div_codeword !== rp[w] || bus.grant_id !== w[0 +: $bits(bus.grant_id)]) begin
      errors++;
      $display("FAIL issue_latch: data=%h poly=%b gid=%0d required data=%h poly=%b gid=%0d",
               bus.div_data, bus.div_codeword, bus.grant_id, rd[w], rp[w], w);
    end
    if (!hold) pending[w] = 1'b0;
    drive_reqs();
    if (spur) begin
      bus.div_outready  = 1'b1;
      bus.div_remainder = (CODE_W-1)'($urandom);
    end
    @(negedge clk);
    bus.div_outready = 1'b0;
    checks++;
    if (bus.req_ready !== '0 || bus.div_readready !== 1'b0 || bus.rsp_valid !== '0 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL wait_entry: req_ready=%b readready=%b rsp_valid=%b busy=%b required 0 0 0 1",
               bus.req_ready, bus.div_readready, bus.rsp_valid, bus.busy);
    end
    got_c = -1;
    for (int c = 1; c <= 300 && got_c < 0; c++) begin
      if (delay >= 0 && c == delay + 1) begin
        bus.div_outready  = 1'b1;
        bus.div_remainder = gf_mod(rd[w], rp[w]);
      end
      @(negedge clk);
      bus.div_outready  = 1'b0;
      bus.div_remainder = (CODE_W-1)'($urandom);
      if (bus.rsp_valid !== '0) got_c = c;
    end
    checks++;
    if (got_c != exp_c) begin
      errors++;
      $display("FAIL rsp_timing: response after %0d WAIT cycles required %0d", got_c, exp_c);
    end
    checks++;
    if (bus.rsp_valid !== (NREQ'(1) << w) || bus.rsp_rem !== exp_rem || bus.rsp_err !== exp_err
        || bus.div_reset !== exp_err) begin
      errors++;
      $display("FAIL rsp: valid=%b rem=%h err=%b div_reset=%b required valid=%b rem=%h err=%b div_reset=%b",
               bus.rsp_valid, bus.rsp_rem, bus.rsp_err, bus.div_reset,
               NREQ'(1) << w, exp_rem, exp_err, exp_err);
    end
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.rsp_valid !== '0 || bus.rsp_rem !== '0 || bus.rsp_err !== 1'b0
        || bus.div_reset !== 1'b0) begin
      errors++;
      $display("FAIL back_idle: busy=%b rsp_valid=%b rem=%h err=%b div_reset=%b required all 0",
               bus.busy, bus.rsp_valid, bus.rsp_rem, bus.rsp_err, bus.div_reset);
    end
    exp_last = w;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_last = NREQ - 1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.req_ready !== '0 || bus.rsp_valid !== '0 || bus.div_readready !== 1'b0
        || bus.div_reset !== 1'b1 || bus.grant_id !== '0 || bus.div_data !== '0 || bus.div_codeword !== '0
        || bus.rsp_rem !== '0 || bus.rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: busy=%b rdy=%b rsp=%b rr=%b div_reset=%b gid=%0d data=%h poly=%b required div_reset=1 rest 0",
               bus.busy, bus.req_ready, bus.rsp_valid, bus.div_readready, bus.div_reset,
               bus.grant_id, bus.div_data, bus.div_codeword);
    end
    reset = 1'b0;
    exp_last = NREQ - 1;
    @(negedge clk);
    checks++;
    if (bus.div_reset !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: div_reset=%b busy=%b required 0 0", bus.div_reset, bus.busy);
    end
  endtask

  task automatic test_single();
    int w;
    rd[0] = 31'h10;
    rp[0] = 5'b10011;
    checks++;
    if (gf_mod(rd[0], rp[0]) !== 4'h3) begin
      errors++;
      $display("FAIL single_model: model rem=%h required 3", gf_mod(rd[0], rp[0]));
    end
    pending = 2'b01;
    do_job(9, 1'b0, 1'b0, w);
    checks++;
    if (w != 0) begin
      errors++;
      $display("FAIL single_grant: grant=%0d required 0", w);
    end
  endtask

  task automatic test_back_to_back();
    int w;
    pulse_reset();
    for (int i = 0; i < NREQ; i++) begin
      rd[i] = DATA_W'(32'h1111_0000 * (i + 1) + $urandom_range(0, 255));
      rp[i] = {1'b1, (CODE_W-1)'($urandom)};
    end
    pending = '1;
    for (int k = 0; k < 4; k++) begin
      do_job($urandom_range(0, 12), 1'b1, 1'b0, w);
      checks++;
      if (w != (k % 2)) begin
        errors++;
        $display("FAIL b2b_order: job %0d grant=%0d required %0d", k, w, k % 2);
      end
    end
    pending = '0;
    drive_reqs();
  endtask

  task automatic test_timeout();
    int w;
    pending = 2'b01;
    new_job(0);
    do_job(-1, 1'b0, 1'b0, w);
    pending = 2'b10;
    new_job(1);
    do_job(5, 1'b0, 1'b0, w);
    checks++;
    if (w != 1) begin
      errors++;
      $display("FAIL after_timeout: grant=%0d required 1", w);
    end
  endtask

  task automatic test_reset_wait();
    int w;
    pending = 2'b01;
    new_job(0);
    do_job(3, 1'b0, 1'b0, w);
    pending = 2'b10;
    new_job(1);
    drive_reqs();
    @(posedge clk); @(negedge clk);
    pending = '0;
    drive_reqs();
    repeat (5) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1 || bus.grant_id !== 1'b1) begin
      errors++;
      $display("FAIL rw_pre: busy=%b gid=%0d required 1 1", bus.busy, bus.grant_id);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.rsp_valid !== '0 || bus.req_ready !== '0 || bus.div_readready !== 1'b0
        || bus.div_reset !== 1'b1 || bus.grant_id !== '0 || bus.div_data !== '0 || bus.div_codeword !== '0) begin
      errors++;
      $display("FAIL rw_reset: busy=%b rsp=%b rdy=%b div_reset=%b gid=%0d data=%h required div_reset=1 rest 0",
               bus.busy, bus.rsp_valid, bus.req_ready, bus.div_reset, bus.grant_id, bus.div_data);
    end
    reset = 1'b0;
    exp_last = NREQ - 1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (bus.rsp_valid !== '0 || bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL rw_quiet: rsp_valid=%b busy=%b required 0 0", bus.rsp_valid, bus.busy);
      end
    end
    pending = 2'b11;
    new_job(0);
    new_job(1);
    do_job(4, 1'b0, 1'b0, w);
    checks++;
    if (w != 0) begin
      errors++;
      $display("FAIL rw_first: grant=%0d required 0", w);
    end
    do_job(2, 1'b0, 1'b0, w);
  endtask

  task automatic test_spurious();
    int w;
    pending = '0;
    drive_reqs();
    bus.div_outready  = 1'b1;
    bus.div_remainder = (CODE_W-1)'($urandom);
    @(negedge clk);
    bus.div_outready = 1'b0;
    checks++;
    if (bus.rsp_valid !== '0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL spur_idle: rsp_valid=%b busy=%b required 0 0", bus.rsp_valid, bus.busy);
    end
    pending = 2'b10;
    new_job(1);
    do_job(6, 1'b0, 1'b1, w);
  endtask

  task automatic test_same_cycle();
    int w;
    pending = 2'b01;
    new_job(0);
    do_job(TIMEOUT - 1, 1'b0, 1'b0, w);
  endtask

  task automatic test_random();
    int w;
    logic [NREQ-1:0] add;
    for (int k = 0; k < 12; k++) begin
      add = NREQ'($urandom);
      for (int i = 0; i < NREQ; i++)
        if (add[i] && !pending[i]) new_job(i);
      pending = pending | add;
      if (($urandom % 4) == 0) pending[$urandom % NREQ] = 1'b0;
      if (pending == '0) begin
        pending[0] = 1'b1;
        new_job(0);
      end
      do_job((($urandom % 8) == 0) ? -1 : int'($urandom_range(0, 30)), 1'b0, 1'b0, w);
    end
    pending = '0;
    drive_reqs();
  endtask

  initial begin
    reset = 1'b1;
    pending = '0;
    exp_last = NREQ - 1;
    bus.req_valid = '0;
    bus.req_data = '0;
    bus.req_poly = '0;
    bus.div_outready = 1'b0;
    bus.div_remainder = '0;
    for (int i = 0; i < NREQ; i++) begin
      rd[i] = '0;
      rp[i] = '0;
    end
    test_reset();
    test_single();
    test_back_to_back();
    test_timeout();
    test_reset_wait();
    test_spurious();
    test_same_cycle();
    test_random();
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/bch_div_scheduler.md
Name: bch_div_scheduler

Overview:
- Round-robin controller that shares one serial polynomial-division unit (binary_divison: start/done handshake, 31-bit dividend, 5-bit generator, 4-bit remainder) between NREQ requesters, e.g. the BCH encoder checkbit path and the decoder syndrome path.
- Latches the winning request, sequences the divider start pulse, and waits for completion under a watchdog.
- Returns the remainder, plus an error flag, to the requester that issued the job.

Parameters:
- NREQ, 2, number of requesters (2..8).
- DATA_W, 31, dividend width.
- CODE_W, 5, generator polynomial width; the remainder is CODE_W-1 bits.
- TIMEOUT, 128, maximum WAIT cycles before the job is aborted.

Ports:
- clk  in  1  clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  request i pending; held until req_ready[i] is seen high.
- req_data  in  NREQ*DATA_W  dividend; slice i is [i*DATA_W +: DATA_W].
- req_poly  in  NREQ*CODE_W  generator; slice i is [i*CODE_W +: CODE_W].
- req_ready  out  NREQ  one-cycle accept pulse, one-hot.
- rsp_valid  out  NREQ  one-cycle result pulse, one-hot.
- rsp_rem  out  CODE_W-1  remainder, valid while any rsp_valid bit is high.
- rsp_err  out  1  timeout flag, valid with rsp_valid.
- busy  out  1  high in every state except IDLE.
- grant_id  out  clog2(NREQ)  index of the job in flight.
- div_readready  out  1  divider start pulse.
- div_data  out  DATA_W  latched dividend.
- div_codeword  out  CODE_W  latched generator.
- div_reset  out  1  divider reset; equals reset OR the abort pulse.
- div_outready  in  1  divider done.
- div_remainder  in  CODE_W-1  divider result.

Behaviour:
- Clocking and reset: one clock. Reset is synchronous and active-high.
- Reset values: state=IDLE; all outputs 0 except div_reset=1; last_grant=NREQ-1, so requester 0 wins first; timer=0.
- Reset mid-operation (any state) returns to IDLE next edge. No rsp_valid is produced for the aborted job.
- FSM IDLE:
  - If any req_valid bit is set, pick the winner w by searching from last_grant+1 upward, modulo NREQ.
  - Latch req_data[w], req_poly[w] and w into registers; go to ISSUE.
  - Stay in IDLE otherwise.
- FSM ISSUE (1 cycle):
  - req_ready[w]=1 and div_readready=1.
  - div_data and div_codeword are driven from the latches; they stay stable from ISSUE until IDLE.
  - Clear timer; go to WAIT.
- FSM WAIT:
  - If div_outready=1, capture div_remainder, set err=0, go to RESPOND.
  - Else if timer==TIMEOUT-1, set rem=0, err=1, go to RESPOND.
  - Else timer+1. The timer is clog2(TIMEOUT) bits and never wraps.
  - div_outready is sampled only in WAIT and ignored in every other state.
  - div_outready and timeout in the same cycle: the done result wins, err=0.
- FSM RESPOND (1 cycle):
  - rsp_valid[w]=1; rsp_rem and rsp_err driven from the latches.
  - If err=1, div_reset=1 for this cycle.
  - last_grant<=w; go to IDLE.
- Latency: request seen in IDLE at cycle 0 → req_ready/div_readready at cycle 1. Divider done at cycle k≥2 → rsp_valid at cycle k+1 → IDLE at cycle k+2.
- Throughput: one job at a time; no queueing.
- Requester rules:
  - A requester dropping req_valid before its grant gets no service and no error.
  - A requester re-asserting req_valid immediately after being served has lowest priority in the next arbitration.
- Output rules:
  - req_ready and rsp_valid are each at most one-hot and each is asserted only in its own state.
  - rsp_rem=0 and rsp_err=0 whenever rsp_valid=0.

Test Plan:
- Single request: req_valid=2'b01, data=31'h10, poly=5'b10011; divider model returns 4'h3 after 10 WAIT cycles → req_ready=2'b01 at cycle 1, rsp_valid=2'b01 with rsp_rem=4'h3 and rsp_err=0 at cycle 12, busy falls at cycle 13.
- Simultaneous requests: req_valid=2'b11 held continuously after reset → grants in order 0,1,0,1. Each rsp_valid matches its grant; div_data alternates between the two dividends.
- Timeout: divider model never asserts done → after 128 WAIT cycles rsp_valid=2'b01, rsp_rem=0, rsp_err=1, div_reset=1 for exactly 1 cycle. The next request is then served normally.
- Reset in WAIT: assert reset for 1 cycle on WAIT cycle 5 → state=IDLE, no rsp_valid, outputs at reset values. A later request with NREQ=2 is granted to requester 0 first.
- Spurious done: div_outready pulses during IDLE and during ISSUE → ignored, no response. Only the pulse in WAIT produces rsp_valid.
- Same-cycle done and timeout: done arrives at WAIT timer=127 → rsp_err=0 and rsp_rem equals the model's remainder.
